qrisc32_mem_access: RTL and testbench

- Memory-access stage directly downstream of the execute stage in the qrisc32 pipeline.
- Consumes the execute-stage pipe_struct: val_r1 carries the computed load/store address.
- Performs data-memory loads/stores over a req/ack bus with wait states and timeout, generates the pipeline stall for upstream stages, and hands the result to writeback.
- Registers the execute stage's jump redirect (new_address_valid/new_address) toward fetch.

---
 rtl/qrisc32_mem_access.sv | 233 +++++++++++++++++++++++
 tb/tb_qrisc32_mem_access.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qrisc32_mem_access.sv
// qrisc32 memory-access stage.
//
// Sits directly after the execute stage. Load/store instructions are issued
// on a simple req/ack data-memory bus (dmem_rd / dmem_wr held until
// dmem_ack). Wait states are tolerated up to TIMEOUT cycles, after which the
// access is aborted. While an access is pending, upstream stages are stalled
// and bubbles are sent to writeback. Non-memory instructions pass through
// with one register stage. The execute stage's jump redirect is registered
// here on its way to fetch.
//
// Ports:
//   clk, reset           pipeline clock, asynchronous active-low reset
//   pipe_mem_in          instruction from execute (val_r1 = address,
//                        val_dst = store data)
//   pipe_mem_out         registered instruction to writeback
//   pipe_stall           combinational stall to fetch/decode/execute
//   new_address_valid    jump-taken pulse from execute
//   new_address          jump target from execute
//   pc_load, pc_value    registered jump redirect to fetch
//   dmem_addr/wdata      data memory word address / store data
//   dmem_rd/wr           read / write request, held until ack or timeout
//   dmem_rdata/ack       load data / request complete
//   bus_err              sticky timeout flag, cleared only by reset

package qrisc32_pkg;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] val_r1;
    logic [31:0] val_r2;
    logic [31:0] val_dst;
    logic [4:0]  dst_r;
    logic        write_reg;
    logic        add_op;
    logic        read_mem;
    logic        write_mem;
  } pipe_struct;

endpackage

module qrisc32_mem_access
  import qrisc32_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  pipe_struct  pipe_mem_in,
  output pipe_struct  pipe_mem_out,
  output logic        pipe_stall,
  input  logic        new_address_valid,
  input  logic [31:0] new_address,
  output logic        pc_load,
  output logic [31:0] pc_value,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_rd,
  output logic        dmem_wr,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        bus_err
);

  // Counter wide enough to hold TIMEOUT-1; at least one bit for TIMEOUT==1.
  localparam int unsigned      CNT_W    = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  state_e           state_r;
  state_e           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  pipe_struct       pipe_mem_out_r;
  pipe_struct       out_s;
  logic             mem_op_s;
  logic             timeout_s;
  logic             stall_s;
  logic             start_s;
  logic             done_s;
  logic             set_err_s;
  logic [31:0]      dmem_addr_r;
  logic [31:0]      dmem_wdata_r;
  logic             dmem_rd_r;
  logic             dmem_wr_r;
  logic             bus_err_r;
  logic             pc_load_r;
  logic [31:0]      pc_value_r;

  // Next-state, stall and writeback-payload decode.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    out_s     = pipe_mem_in;
    stall_s   = 1'b0;
    start_s   = 1'b0;
    done_s    = 1'b0;
    set_err_s = 1'b0;
    mem_op_s  = pipe_mem_in.read_mem | pipe_mem_in.write_mem;
    // Ack wins over timeout when both happen on the last allowed cycle.
    timeout_s = (state_r == ST_ACCESS) && !dmem_ack && (cnt_r == CNT_LAST);

    case (state_r)
      ST_IDLE: begin
        if (mem_op_s) begin
          stall_s = 1'b1;
          out_s   = '0;
          start_s = 1'b1;
          cnt_s   = '0;
          state_s = ST_ACCESS;
        end else begin
          out_s = pipe_mem_in;
        end
      end

      ST_ACCESS: begin
        if (dmem_ack) begin
          // Upstream still holds the instruction, so it is reused here.
          out_s   = pipe_mem_in;
          if (dmem_rd_r) begin
            out_s.val_dst = dmem_rdata;
          end else begin
            out_s.val_dst = pipe_mem_in.val_dst;
          end
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else if (timeout_s) begin
          // Aborted access completes like a normal one, loads return ERR_DATA.
          out_s     = pipe_mem_in;
          if (dmem_rd_r) begin
            out_s.val_dst = ERR_DATA;
          end else begin
            out_s.val_dst = pipe_mem_in.val_dst;
          end
          done_s    = 1'b1;
          set_err_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          stall_s = 1'b1;
          out_s   = '0;
          cnt_s   = cnt_r + CNT_W'(32'd1);
        end
      end

      default: begin
        out_s   = '0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Writeback payload register (bubble while an access is pending).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_mem_out_r <= '0;
    end else begin
      pipe_mem_out_r <= out_s;
    end
  end

  // Data-memory request registers: loaded on detect, held until completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_addr_r  <= 32'h0000_0000;
      dmem_wdata_r <= 32'h0000_0000;
      dmem_rd_r    <= 1'b0;
      dmem_wr_r    <= 1'b0;
    end else if (start_s) begin
      dmem_addr_r  <= pipe_mem_in.val_r1;
      dmem_wdata_r <= pipe_mem_in.val_dst;
      // A combined read+write request is treated as a write.
      dmem_rd_r    <= ~pipe_mem_in.write_mem;
      dmem_wr_r    <= pipe_mem_in.write_mem;
    end else if (done_s) begin
      dmem_rd_r    <= 1'b0;
      dmem_wr_r    <= 1'b0;
    end else begin
      dmem_rd_r    <= dmem_rd_r;
      dmem_wr_r    <= dmem_wr_r;
    end
  end

  // Sticky bus-error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_err_r <= 1'b0;
    end else begin
      bus_err_r <= bus_err_r | set_err_s;
    end
  end

  // Jump redirect toward fetch; independent of the FSM and of the stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_load_r  <= 1'b0;
      pc_value_r <= 32'h0000_0000;
    end else begin
      pc_load_r <= new_address_valid;
      if (new_address_valid) begin
        pc_value_r <= new_address;
      end else begin
        pc_value_r <= pc_value_r;
      end
    end
  end

  // Stall drops as soon as reset is asserted, even with a memory op waiting.
  assign pipe_stall   = stall_s & reset;
  assign pipe_mem_out = pipe_mem_out_r;
  assign dmem_addr    = dmem_addr_r;
  assign dmem_wdata   = dmem_wdata_r;
  assign dmem_rd      = dmem_rd_r;
  assign dmem_wr      = dmem_wr_r;
  assign bus_err      = bus_err_r;
  assign pc_load      = pc_load_r;
  assign pc_value     = pc_value_r;

endmodule

// File: tb/tb_qrisc32_mem_access.sv
`timescale 1ns/1ps
module tb_qrisc32_mem_access;
  import qrisc32_pkg::*;

  localparam int          TMO  = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam pipe_struct  BUBBLE = '0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  pipe_struct  pin;
  pipe_struct  pout;
  logic        stall;
  logic        nav;
  logic [31:0] na;
  logic        pc_load;
  logic [31:0] pc_value;
  logic [31:0] daddr, dwdata, drdata;
  logic        drd, dwr, dack, berr;

  always #5 clk = ~clk;

  qrisc32_mem_access #(.TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .reset(reset),
    .pipe_mem_in(pin), .pipe_mem_out(pout), .pipe_stall(stall),
    .new_address_valid(nav), .new_address(na),
    .pc_load(pc_load), .pc_value(pc_value),
    .dmem_addr(daddr), .dmem_wdata(dwdata), .dmem_rd(drd), .dmem_wr(dwr),
    .dmem_rdata(drdata), .dmem_ack(dack), .bus_err(berr)
  );

  // ---------------- memory slave with programmable wait states -------------
  int          slv_wait = 0;
  int          slv_cnt;
  logic        force_ack = 1'b0;
  logic [31:0] smem [64];
  logic        swr  [64];

  function automatic logic [31:0] init_val(input int a);
    return 32'hA500_0000 ^ (32'(a) * 32'h0101_0101);
  endfunction

  assign dack   = (((drd | dwr) && (slv_cnt == slv_wait)) || force_ack);
  assign drdata = swr[daddr[5:0]] ? smem[daddr[5:0]] : init_val(int'(daddr[5:0]));

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) swr[i] <= 1'b0;
      slv_cnt <= 0;
    end else begin
      if ((drd | dwr) && !dack) slv_cnt <= slv_cnt + 1;
      else                      slv_cnt <= 0;
      if (dwr && dack) begin
        swr[daddr[5:0]]  <= 1'b1;
        smem[daddr[5:0]] <= dwdata;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] ref_mem [64];
  logic        exp_err;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    exp_err = 1'b0;
  endtask

  // Latency of a memory op is 2 + wait states, or TMO + 1 when aborted;
  // the stall covers every cycle of it except the final one.
  task automatic model(input pipe_struct p, input int w, output pipe_struct e, output int est);
    bit mem, rd, tmo;
    mem = p.read_mem | p.write_mem;
    rd  = p.read_mem & ~p.write_mem;
    tmo = mem && (w >= TMO);
    e   = p;
    if (!mem)     est = 0;
    else if (tmo) est = (TMO + 1) - 1;
    else          est = (2 + w) - 1;
    if (rd) e.val_dst = tmo ? ERRD : ref_mem[p.val_r1[5:0]];
    else if (mem && !tmo) ref_mem[p.val_r1[5:0]] = p.val_dst;
    if (tmo) exp_err = 1'b1;
  endtask

  function automatic pipe_struct mk_op(input int kind, input logic [31:0] addr, input logic [31:0] data);
    pipe_struct p;
    p           = '0;
    p.ir        = $urandom;
    p.val_r2    = $urandom;
    p.dst_r     = 5'($urandom);
    p.write_reg = (kind == 0) || (kind == 1);
    p.add_op    = (kind == 0);
    p.read_mem  = (kind == 1) || (kind == 3);
    p.write_mem = (kind == 2) || (kind == 3);
    p.val_r1    = addr;
    p.val_dst   = data;
    return p;
  endfunction

  // Drive one instruction (called #1 after a posedge), hold it while stalled,
  // optionally pulse a jump on stall cycle jump_at, and return what writeback saw.
  task automatic run_op(input pipe_struct p, input int w, input int jump_at, input logic [31:0] jaddr,
                        output int act_st, output pipe_struct act_out, output logic act_err);
    bit is_mem, is_rd, bad_bubble, bad_hold, drop_pending;
    is_mem = p.read_mem | p.write_mem;
    is_rd  = p.read_mem & ~p.write_mem;
    bad_bubble = 0; bad_hold = 0; drop_pending = 0;
    slv_wait = w;
    pin = p;
    act_st = 0;
    @(negedge clk);
    while (stall && act_st < TMO + 4) begin
      if (act_st > 0 && (daddr !== p.val_r1 || dwdata !== p.val_dst || drd !== is_rd || dwr !== !is_rd))
        bad_hold = 1;
      if (act_st == jump_at) begin nav = 1'b1; na = jaddr; end
      act_st++;
      @(posedge clk); #1;
      if (pout !== BUBBLE) bad_bubble = 1;
      if (drop_pending) begin
        chk("pc_load_drop", {pc_load, pc_value}, {1'b0, jaddr});
        drop_pending = 0;
      end
      if (nav) begin
        chk("jump_redirect", {pc_load, pc_value}, {1'b1, jaddr});
        nav = 1'b0;
        drop_pending = 1;
      end
      @(negedge clk);
    end
    chk("bubble_while_stalled", 160'(bad_bubble), 160'(0));
    if (is_mem) begin
      chk("req_stable", 160'(bad_hold), 160'(0));
      chk("req_at_completion", {drd, dwr, daddr, dwdata}, {is_rd, !is_rd, p.val_r1, p.val_dst});
    end else begin
      chk("no_req_alu", {drd, dwr}, {1'b0, 1'b0});
    end
    @(posedge clk); #1;
    if (drop_pending) chk("pc_load_drop", {pc_load, pc_value}, {1'b0, jaddr});
    chk("req_released", {drd, dwr}, {1'b0, 1'b0});
    act_out = pout;
    act_err = berr;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          kind;      // 0 alu, 1 load, 2 store, 3 read+write (store)
    logic [31:0] addr;
    logic [31:0] data;
    int          w;         // slave wait states
    int          jump_at;   // stall cycle to pulse a jump on, -1 none
    logic [31:0] jaddr;
    int          exp_stall;
    logic [31:0] exp_val;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         st;
    pipe_struct o, e;
    logic       er;
    pin = BUBBLE; nav = 1'b0; na = 32'h0;
    model_reset();

    tbl.push_back('{0, 32'h0000_0000, 32'h0000_0005, 0, -1, 32'h0, 0, 32'h0000_0005, 1'b0});
    tbl.push_back('{2, 32'h0000_0100, 32'hCAFE_0001, 0, -1, 32'h0, 1, 32'hCAFE_0001, 1'b0});
    tbl.push_back('{1, 32'h0000_0100, 32'h0000_7777, 0, -1, 32'h0, 1, 32'hCAFE_0001, 1'b0});
    tbl.push_back('{2, 32'h0000_0020, 32'h0000_1234, 3,  2, 32'h0000_0400, 4, 32'h0000_1234, 1'b0});
    tbl.push_back('{1, 32'h0000_0020, 32'h0000_0000, 2, -1, 32'h0, 3, 32'h0000_1234, 1'b0});
    tbl.push_back('{3, 32'h0000_0024, 32'h0000_55AA, 1, -1, 32'h0, 2, 32'h0000_55AA, 1'b0});
    tbl.push_back('{1, 32'h0000_0024, 32'h0000_0000, 0, -1, 32'h0, 1, 32'h0000_55AA, 1'b0});
    tbl.push_back('{0, 32'h0000_0000, 32'h0000_0009, 0, -1, 32'h0, 0, 32'h0000_0009, 1'b0});
    tbl.push_back('{1, 32'h0000_0008, 32'h0000_0000, 3, -1, 32'h0, 4, init_val(8), 1'b0});
    tbl.push_back('{1, 32'h0000_0030, 32'h0000_0000, 4,  1, 32'h0000_0800, 4, ERRD, 1'b1});
    tbl.push_back('{2, 32'h0000_0030, 32'h0000_BBBB, 0, -1, 32'h0, 1, 32'h0000_BBBB, 1'b1});
    tbl.push_back('{2, 32'h0000_0031, 32'h0000_CCCC, 9, -1, 32'h0, 4, 32'h0000_CCCC, 1'b1});
    tbl.push_back('{1, 32'h0000_0031, 32'h0000_0000, 0, -1, 32'h0, 1, init_val(49), 1'b1});

    // Reset state
    #12;
    chk("reset_out", pout, BUBBLE);
    chk("reset_bus", {drd, dwr, daddr, dwdata}, 66'h0);
    chk("reset_pc_err_stall", {pc_load, pc_value, berr, stall}, 35'h0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      run_op(mk_op(tbl[i].kind, tbl[i].addr, tbl[i].data), tbl[i].w, tbl[i].jump_at, tbl[i].jaddr, st, o, er);
      chk($sformatf("vec%0d_stall", i), 160'(st), 160'(tbl[i].exp_stall));
      chk($sformatf("vec%0d_val", i), o.val_dst, tbl[i].exp_val);
      chk($sformatf("vec%0d_err", i), er, tbl[i].exp_err);
    end

    // Reset in the middle of a load: request dropped, stall released at once.
    pin = mk_op(1, 32'h0000_0010, 32'h0);
    slv_wait = 99;
    @(posedge clk); #1;
    chk("midreset_pre_rd", {drd, stall}, {1'b1, 1'b1});
    #2 reset = 1'b0;
    #1;
    chk("midreset_rd_stall", {drd, dwr, stall}, 3'b000);
    chk("midreset_state", {pout, berr, pc_load, pc_value, daddr}, {BUBBLE, 1'b0, 1'b0, 32'h0, 32'h0});
    pin = mk_op(0, 32'h0, 32'h0000_0077);
    force_ack = 1'b1;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("late_ack_ignored", pout, pin);
    chk("late_ack_no_req", {drd, dwr, berr}, 3'b000);
    force_ack = 1'b0;
    model_reset();

    // Randomized stream against the transaction-level model.
    for (int n = 0; n < 60; n++) begin
      int          kind, w, r, ja;
      logic [31:0] jaddr;
      pipe_struct  p;
      int          est;
      kind  = $urandom_range(0, 3);
      r     = $urandom_range(0, 9);
      w     = (r < 7) ? (r % 4) : (r - 3);
      ja    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
      jaddr = $urandom;
      p     = mk_op(kind, $urandom, $urandom);
      model(p, w, e, est);
      run_op(p, w, ja, jaddr, st, o, er);
      chk($sformatf("rnd%0d_stall", n), 160'(st), 160'(est));
      chk($sformatf("rnd%0d_out", n), o, e);
      chk($sformatf("rnd%0d_err", n), er, exp_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
